// File: rtl/pipe_sequencer.sv
// pipe_sequencer: pipeline control FSM for fetch, load-use stalls,
// halt draining and blocking tensor-unit operations.
module pipe_sequencer #(
  parameter int PC_WIDTH       = 10,
  parameter int REG_ADDR_WIDTH = 4,
  parameter int DRAIN_CYCLES   = 3,
  parameter int TENSOR_TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      dec_valid,
  input  logic [REG_ADDR_WIDTH-1:0] dec_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] dec_rs2,
  input  logic                      dec_is_halt,
  input  logic                      dec_is_tensor,
  input  logic                      ex_is_ld,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  input  logic                      tensor_done,
  output logic [PC_WIDTH-1:0]       pc,
  output logic                      fetch_en,
  output logic                      ex_en,
  output logic                      ex_bubble,
  output logic                      tensor_start,
  output logic                      halted,
  output logic                      tensor_err
);

  localparam int DW =
    (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;
  localparam int TW =
    (TENSOR_TIMEOUT > 1) ? $clog2(TENSOR_TIMEOUT + 1) : 1;

  // Drain counter is loaded with N-1 so DRAIN lasts N cycles.
  localparam logic [DW-1:0] DRAIN_LOAD =
    DW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
  // Last TWAIT cycle index before giving up on the tensor unit.
  localparam logic [TW-1:0] T_LAST =
    TW'((TENSOR_TIMEOUT > 0) ? TENSOR_TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_TWAIT,
    S_DRAIN,
    S_HALTED
  } state_e;

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [DW-1:0]       dcnt_q, dcnt_d;
  logic [TW-1:0]       tcnt_q, tcnt_d;
  logic                halted_q, halted_d;
  logic                err_q, err_d;
  logic                hazard;

  assign hazard = dec_valid & ex_is_ld &
                  ((ex_rd == dec_rs1) | (ex_rd == dec_rs2));

  // Next-state and per-cycle pipeline control decode.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    dcnt_d       = dcnt_q;
    tcnt_d       = tcnt_q;
    halted_d     = halted_q;
    err_d        = err_q;
    fetch_en     = 1'b0;
    ex_en        = 1'b1;
    ex_bubble    = 1'b1;
    tensor_start = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          pc_d    = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (hazard) begin
          // stall: bubble into EX, hold pc
        end else if (dec_valid && dec_is_halt) begin
          ex_bubble = 1'b0;
          dcnt_d    = DRAIN_LOAD;
          state_d   = S_DRAIN;
        end else if (dec_valid && dec_is_tensor) begin
          ex_bubble    = 1'b0;
          tensor_start = 1'b1;
          tcnt_d       = '0;
          state_d      = S_TWAIT;
        end else begin
          fetch_en  = 1'b1;
          ex_bubble = 1'b0;
          pc_d      = pc_q + PC_WIDTH'(1);
        end
      end
      S_TWAIT: begin
        ex_en     = 1'b0;
        ex_bubble = 1'b0;
        if (tensor_done) begin
          state_d = S_RUN;
        end else if (tcnt_q == T_LAST) begin
          halted_d = 1'b1;
          err_d    = 1'b1;
          state_d  = S_HALTED;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      S_DRAIN: begin
        if (dcnt_q == '0) begin
          halted_d = 1'b1;
          state_d  = S_HALTED;
        end else begin
          dcnt_d = dcnt_q - DW'(1);
        end
      end
      S_HALTED: begin
        if (start) begin
          halted_d = 1'b0;
          pc_d     = '0;
          state_d  = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      dcnt_q   <= '0;
      tcnt_q   <= '0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      dcnt_q   <= dcnt_d;
      tcnt_q   <= tcnt_d;
      halted_q <= halted_d;
      err_q    <= err_d;
    end
  end

  assign pc         = pc_q;
  assign halted     = halted_q;
  assign tensor_err = err_q;

endmodule

// File: tb/tb_pipe_sequencer.sv
// tb_pipe_sequencer: vector table, directed corner sequences and
// randomized run against an abstract sequencer model.
module tb_pipe_sequencer;

  localparam int PW  = 4;
  localparam int RW  = 4;
  localparam int DRN = 3;
  localparam int TMO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, start, dec_valid;
  logic [RW-1:0] dec_rs1, dec_rs2, ex_rd;
  logic          dec_is_halt, dec_is_tensor;
  logic          ex_is_ld, tensor_done;

  logic [PW-1:0] pc;
  logic fetch_en, ex_en, ex_bubble;
  logic tensor_start, halted, tensor_err;

  logic [9:0] w_pc;
  logic w_fe, w_ee, w_eb, w_ts, w_h, w_err;

  pipe_sequencer #(
    .PC_WIDTH(PW), .REG_ADDR_WIDTH(RW),
    .DRAIN_CYCLES(DRN), .TENSOR_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .dec_valid(dec_valid), .dec_rs1(dec_rs1),
    .dec_rs2(dec_rs2), .dec_is_halt(dec_is_halt),
    .dec_is_tensor(dec_is_tensor), .ex_is_ld(ex_is_ld),
    .ex_rd(ex_rd), .tensor_done(tensor_done),
    .pc(pc), .fetch_en(fetch_en), .ex_en(ex_en),
    .ex_bubble(ex_bubble), .tensor_start(tensor_start),
    .halted(halted), .tensor_err(tensor_err)
  );

  pipe_sequencer dut_w (
    .clk(clk), .rst_n(rst_n), .start(start),
    .dec_valid(dec_valid), .dec_rs1(dec_rs1),
    .dec_rs2(dec_rs2), .dec_is_halt(dec_is_halt),
    .dec_is_tensor(dec_is_tensor), .ex_is_ld(ex_is_ld),
    .ex_rd(ex_rd), .tensor_done(tensor_done),
    .pc(w_pc), .fetch_en(w_fe), .ex_en(w_ee),
    .ex_bubble(w_eb), .tensor_start(w_ts),
    .halted(w_h), .tensor_err(w_err)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  task automatic set_in(input logic r, st, dv,
                        input logic [3:0] a, b,
                        input logic hl, tn, ld,
                        input logic [3:0] rd,
                        input logic dn);
    rst_n = r; start = st; dec_valid = dv;
    dec_rs1 = a; dec_rs2 = b;
    dec_is_halt = hl; dec_is_tensor = tn;
    ex_is_ld = ld; ex_rd = rd; tensor_done = dn;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    adv();
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  typedef struct {
    logic st, dv;
    logic [3:0] a, b;
    logic hl, tn, ld;
    logic [3:0] rd;
    logic dn;
    int pc;
    logic fe, ee, eb, ts, h;
  } vec_t;

  function automatic vec_t v(
    logic st, dv, logic [3:0] a, b,
    logic hl, tn, ld, logic [3:0] rd, logic dn,
    int p, logic fe, ee, eb, ts, h);
    vec_t r;
    r.st = st; r.dv = dv; r.a = a; r.b = b;
    r.hl = hl; r.tn = tn; r.ld = ld; r.rd = rd;
    r.dn = dn; r.pc = p; r.fe = fe; r.ee = ee;
    r.eb = eb; r.ts = ts; r.h = h;
    return r;
  endfunction

  // abstract model of the main instance
  localparam int MI = 0, MR = 1, MW = 2, MD = 3, MH = 4;
  int m_mode, m_pc, m_left, m_wait;
  bit m_h, m_e;

  task automatic m_reset();
    m_mode = MI; m_pc = 0; m_left = 0;
    m_wait = 0; m_h = 0; m_e = 0;
  endtask

  function automatic bit m_hz();
    return dec_valid && ex_is_ld &&
           (ex_rd == dec_rs1 || ex_rd == dec_rs2);
  endfunction

  task automatic m_check();
    bit hz;
    int fe, ee, eb, ts;
    hz = m_hz();
    fe = 0; ee = 1; eb = 1; ts = 0;
    if (m_mode == MR) begin
      if (hz) begin
        eb = 1;
      end else if (dec_valid && dec_is_halt) begin
        eb = 0;
      end else if (dec_valid && dec_is_tensor) begin
        eb = 0; ts = 1;
      end else begin
        fe = 1; eb = 0;
      end
    end else if (m_mode == MW) begin
      ee = 0;
    end
    chk("rnd_pc", pc, m_pc);
    chk("rnd_fetch_en", fetch_en, fe);
    chk("rnd_ex_en", ex_en, ee);
    if (m_mode != MW) chk("rnd_ex_bubble", ex_bubble, eb);
    chk("rnd_tensor_start", tensor_start, ts);
    chk("rnd_halted", halted, m_h);
    chk("rnd_tensor_err", tensor_err, m_e);
  endtask

  task automatic m_step();
    bit hz;
    hz = m_hz();
    if (!rst_n) begin
      m_reset();
      return;
    end
    case (m_mode)
      MI: if (start) begin m_mode = MR; m_pc = 0; end
      MR: begin
        if (hz) begin
        end else if (dec_valid && dec_is_halt) begin
          m_mode = MD; m_left = DRN;
        end else if (dec_valid && dec_is_tensor) begin
          m_mode = MW; m_wait = 0;
        end else begin
          m_pc = (m_pc + 1) % (1 << PW);
        end
      end
      MW: begin
        m_wait++;
        if (tensor_done) m_mode = MR;
        else if (m_wait == TMO) begin
          m_mode = MH; m_h = 1; m_e = 1;
        end
      end
      MD: begin
        m_left--;
        if (m_left == 0) begin m_mode = MH; m_h = 1; end
      end
      MH: if (start) begin
        m_mode = MR; m_pc = 0; m_h = 0;
      end
      default: m_mode = MI;
    endcase
  endtask

  vec_t tbl[$];
  int pulses;

  initial begin
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    adv();
    do_reset();

    // reset state
    settle();
    chk("rst_pc", pc, 0);
    chk("rst_fetch_en", fetch_en, 0);
    chk("rst_ex_en", ex_en, 1);
    chk("rst_ex_bubble", ex_bubble, 1);
    chk("rst_tensor_start", tensor_start, 0);
    chk("rst_halted", halted, 0);
    chk("rst_tensor_err", tensor_err, 0);
    adv();

    tbl.push_back(v(1,0,1,2,0,0,0,0,0, 0,0,1,1,0,0));
    for (int k = 0; k < 7; k++)
      tbl.push_back(v(0,1,1,2,0,0,0,0,0, k,1,1,0,0,0));
    tbl.push_back(v(0,1,1,3,0,0,1,3,0, 7,0,1,1,0,0));
    tbl.push_back(v(0,1,1,3,0,0,0,3,0, 7,1,1,0,0,0));
    tbl.push_back(v(1,1,1,2,0,0,0,0,0, 8,1,1,0,0,0));
    tbl.push_back(v(0,0,3,3,1,1,1,3,0, 9,1,1,0,0,0));
    tbl.push_back(v(0,1,5,2,1,0,1,5,0,10,0,1,1,0,0));
    tbl.push_back(v(0,1,5,2,1,0,0,0,0,10,0,1,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,1,10,0,1,1,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0,10,0,1,1,0,0));
    tbl.push_back(v(1,0,0,0,0,0,0,0,0,10,0,1,1,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0,10,0,1,1,0,1));
    tbl.push_back(v(1,0,0,0,0,0,0,0,0,10,0,1,1,0,1));
    tbl.push_back(v(0,1,1,2,0,0,0,0,0, 0,1,1,0,0,0));
    foreach (tbl[i]) begin
      set_in(1, tbl[i].st, tbl[i].dv, tbl[i].a,
             tbl[i].b, tbl[i].hl, tbl[i].tn,
             tbl[i].ld, tbl[i].rd, tbl[i].dn);
      settle();
      chk($sformatf("tbl%0d_pc", i), pc, tbl[i].pc);
      chk($sformatf("tbl%0d_fe", i), fetch_en, tbl[i].fe);
      chk($sformatf("tbl%0d_ee", i), ex_en, tbl[i].ee);
      chk($sformatf("tbl%0d_eb", i), ex_bubble, tbl[i].eb);
      chk($sformatf("tbl%0d_ts", i), tensor_start,
          tbl[i].ts);
      chk($sformatf("tbl%0d_h", i), halted, tbl[i].h);
      adv();
    end

    // halt at pc 4, halted exactly 4 cycles later
    do_reset();
    set_in(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    adv();
    set_in(1, 0, 1, 1, 2, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      settle();
      chk("halt_seq_pc", pc, k);
      adv();
    end
    set_in(1, 0, 1, 1, 2, 1, 0, 0, 0, 0);
    settle();
    chk("halt_fe", fetch_en, 0);
    chk("halt_eb", ex_bubble, 0);
    chk("halt_pc", pc, 4);
    adv();
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      settle();
      chk($sformatf("drain%0d_halted", k), halted,
          (k == 4) ? 1 : 0);
      chk($sformatf("drain%0d_fe", k), fetch_en, 0);
      chk($sformatf("drain%0d_pc", k), pc, 4);
      adv();
    end
    set_in(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    adv();
    set_in(1, 0, 1, 1, 2, 0, 0, 0, 0, 0);
    settle();
    chk("restart_pc", pc, 0);
    chk("restart_halted", halted, 0);
    adv();

    // pc wrap on the 4-bit instance
    do_reset();
    set_in(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    adv();
    set_in(1, 0, 1, 1, 2, 0, 0, 0, 0, 0);
    for (int k = 0; k < 18; k++) begin
      settle();
      chk($sformatf("wrap%0d_pc", k), pc, k % 16);
      adv();
    end

    // tensor wait on default instance, done after 10 cycles
    do_reset();
    set_in(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    adv();
    set_in(1, 0, 1, 1, 2, 0, 0, 0, 0, 0);
    adv();
    adv();
    set_in(1, 0, 1, 1, 2, 0, 1, 0, 0, 0);
    settle();
    pulses = int'(w_ts);
    chk("tns_start", w_ts, 1);
    chk("tns_fe", w_fe, 0);
    chk("tns_pc", w_pc, 2);
    adv();
    for (int k = 1; k <= 10; k++) begin
      set_in(1, 0, 1, 1, 2, 0, 1, 0, 0, (k == 10));
      settle();
      pulses += int'(w_ts);
      chk($sformatf("twait%0d_ee", k), w_ee, 0);
      chk($sformatf("twait%0d_fe", k), w_fe, 0);
      chk($sformatf("twait%0d_pc", k), w_pc, 2);
      adv();
    end
    set_in(1, 0, 1, 1, 2, 0, 0, 0, 0, 0);
    settle();
    pulses += int'(w_ts);
    chk("resume_pc", w_pc, 2);
    chk("resume_fe", w_fe, 1);
    adv();
    settle();
    chk("resume_next_pc", w_pc, 3);
    chk("tns_pulses", pulses, 1);
    adv();

    // tensor timeout on the main instance
    do_reset();
    set_in(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    adv();
    set_in(1, 0, 1, 1, 2, 0, 1, 0, 0, 0);
    settle();
    chk("tmo_start", tensor_start, 1);
    adv();
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= TMO; k++) begin
      settle();
      chk($sformatf("tmo%0d_err", k), tensor_err, 0);
      chk($sformatf("tmo%0d_h", k), halted, 0);
      chk($sformatf("tmo%0d_ee", k), ex_en, 0);
      adv();
    end
    settle();
    chk("tmo_err", tensor_err, 1);
    chk("tmo_halted", halted, 1);
    set_in(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    adv();
    set_in(1, 0, 1, 1, 2, 0, 0, 0, 0, 0);
    settle();
    chk("tmo_restart_h", halted, 0);
    chk("tmo_restart_err", tensor_err, 1);
    chk("tmo_restart_fe", fetch_en, 1);
    adv();
    do_reset();
    settle();
    chk("tmo_clear_err", tensor_err, 0);
    adv();

    // reset mid-TWAIT with tensor_done in the same cycle
    set_in(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    adv();
    set_in(1, 0, 1, 1, 2, 0, 1, 0, 0, 0);
    adv();
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    adv();
    adv();
    adv();
    set_in(0, 1, 1, 1, 2, 0, 0, 0, 0, 1);
    adv();
    set_in(1, 0, 1, 1, 2, 0, 0, 0, 0, 1);
    settle();
    chk("rtw_pc", pc, 0);
    chk("rtw_fe", fetch_en, 0);
    chk("rtw_ee", ex_en, 1);
    chk("rtw_eb", ex_bubble, 1);
    chk("rtw_ts", tensor_start, 0);
    chk("rtw_h", halted, 0);
    chk("rtw_err", tensor_err, 0);
    adv();
    settle();
    chk("rtw_still_idle", fetch_en, 0);
    adv();

    // randomized run against the model
    do_reset();
    m_reset();
    for (int n = 0; n < 3000; n++) begin
      set_in(($urandom_range(0, 199) != 0),
             ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 3) != 0),
             4'($urandom_range(0, 3)),
             4'($urandom_range(0, 3)),
             ($urandom_range(0, 19) == 0),
             ($urandom_range(0, 11) == 0),
             ($urandom_range(0, 2) == 0),
             4'($urandom_range(0, 3)),
             ($urandom_range(0, 5) == 0));
      settle();
      m_check();
      m_step();
      adv();
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_sequencer.md
PIPE_SEQUENCER -- requirements
Module: pipe_sequencer

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 10: width of the instruction-fetch address.
REQ-002 SHALL have parameter REG_ADDR_WIDTH, default 4: width of register specifiers.
REQ-003 SHALL have parameter DRAIN_CYCLES, default 3: cycles needed to retire in-flight instructions after a halt (EX, MEM, WB).
REQ-004 SHALL have parameter TENSOR_TIMEOUT, default 255: maximum cycles to wait for tensor_done.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  reset, synchronous and active-low.
REQ-007 start  in  1  level; begins execution at PC 0 from IDLE or HALTED.
REQ-008 dec_valid  in  1  the decode stage holds a real instruction.
REQ-009 dec_rs1, dec_rs2  in  REG_ADDR_WIDTH each  decode-stage source registers.
REQ-010 dec_is_halt, dec_is_tensor  in  1 each  decode-stage instruction class.
REQ-011 ex_is_ld  in  1  the EX-stage instruction is a load.
REQ-012 ex_rd  in  REG_ADDR_WIDTH  EX-stage destination register.
REQ-013 tensor_done  in  1  one-cycle pulse from the tensor unit when its result is valid.
REQ-014 pc  out  PC_WIDTH  instruction-fetch address.
REQ-015 fetch_en  out  1  enable for the PC and fetch/decode register.
REQ-016 ex_en  out  1  enable for the decode-to-EX pipeline register.
REQ-017 ex_bubble  out  1  when high, the decode-to-EX register loads a NOP (all control bits 0).
REQ-018 tensor_start  out  1  one-cycle launch pulse to the tensor unit.
REQ-019 halted  out  1  the program has fully retired.
REQ-020 tensor_err  out  1  sticky flag: the tensor unit timed out.

Function
REQ-021 SHALL implement the states IDLE, RUN, TWAIT, DRAIN and HALTED.
REQ-022 IDLE: fetch_en=0, ex_en=1, ex_bubble=1; start=1 SHALL load pc=0 and enter RUN on the next cycle.
REQ-023 RUN, no hazard: fetch_en=1, ex_en=1, ex_bubble=0; pc SHALL increment by 1 per cycle, wrapping from 2^PC_WIDTH-1 to 0.
REQ-024 Load-use hazard: dec_valid & ex_is_ld & (ex_rd==dec_rs1 | ex_rd==dec_rs2) in RUN SHALL produce fetch_en=0 and ex_bubble=1 for exactly that cycle; pc SHALL hold.
REQ-025 A load-use hazard SHALL take priority over halt and tensor detection; those are evaluated on the instruction once the hazard clears.
REQ-026 Halt: dec_valid & dec_is_halt in RUN without hazard SHALL pass the halt instruction to EX (ex_bubble=0), set fetch_en=0, hold pc and enter DRAIN.
REQ-027 DRAIN: fetch_en=0, ex_bubble=1 for DRAIN_CYCLES cycles via a down-counter, then enter HALTED.
REQ-028 HALTED: halted=1, fetch_en=0, ex_bubble=1; start=1 SHALL clear halted, load pc=0 and enter RUN.
REQ-029 Tensor: dec_valid & dec_is_tensor in RUN without hazard SHALL pulse tensor_start for one cycle, pass the instruction to EX, hold pc (fetch_en=0) and enter TWAIT.
REQ-030 TWAIT: fetch_en=0, ex_en=0 (pipeline frozen), tensor_start=0; a timeout counter SHALL count cycles spent in TWAIT.
REQ-031 tensor_done in TWAIT SHALL return to RUN next cycle; pc SHALL advance by 1 in that RUN cycle as normal.
REQ-032 Counter reaching TENSOR_TIMEOUT without tensor_done SHALL set tensor_err=1 and enter HALTED.
REQ-033 tensor_done outside TWAIT SHALL be ignored.
REQ-034 start outside IDLE or HALTED SHALL be ignored.
REQ-035 dec_valid=0 SHALL suppress all hazard, halt and tensor detection.

Reset
REQ-036 rst_n=0 at a rising edge SHALL force, from any state including TWAIT and DRAIN: state IDLE, pc=0, fetch_en=0, ex_en=1, ex_bubble=1, tensor_start=0, halted=0, tensor_err=0, and all counters 0.
REQ-037 Reset SHALL take priority over start, tensor_done and all decode inputs in the same cycle.

Verification
REQ-038 Reset, then start=1 with 5 plain instructions -> pc sequence 0,1,2,3,4; ex_bubble=0 throughout.
REQ-039 ex_is_ld=1, ex_rd=3, dec_rs2=3 at pc=7 -> pc holds at 7 for one cycle with ex_bubble=1, then reads 8.
REQ-040 dec_is_halt at pc=4, DRAIN_CYCLES=3 -> fetch_en=0 from that cycle; halted=1 exactly 4 cycles later; start -> pc=0 and halted=0.
REQ-041 dec_is_tensor at pc=2, tensor_done 10 cycles later -> one tensor_start pulse, ex_en=0 during the wait, pc=2 throughout, then 3 after resume.
REQ-042 TENSOR_TIMEOUT=8 with no tensor_done -> tensor_err=1 and halted=1 after 8 TWAIT cycles; tensor_err cleared only by reset.
REQ-043 rst_n=0 mid-TWAIT, with tensor_done asserted in the same cycle -> all outputs take their REQ-036 values; no return to RUN.
